// File: rtl/fastram_ctrl.sv
// Clocked Zorro II fast-RAM controller: decodes 2MB slots to NUM_BANKS SRAM banks and sequences OE/WE/DTACK.
// Optional write protection is compiled in with `define FASTRAM_WP_EN (adds WP_MASK / WP_VIOLATION).
module fastram_ctrl #(
    parameter int NUM_BANKS      = 2,
    parameter int SLOTS_PER_BANK = 2,
    parameter int WAIT_STATES    = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_n,
    input  logic [2:0]           A,
    input  logic                 RW_n,
    input  logic                 UDS_n,
    input  logic                 LDS_n,
    input  logic                 AS_n,
    input  logic [2:0]           BASE_RAM,
    input  logic                 RAM_CONFIGURED_n,
    input  logic [NUM_BANKS-1:0] BANK_EN,
`ifdef FASTRAM_WP_EN
    input  logic [NUM_BANKS-1:0] WP_MASK,
    output logic                 WP_VIOLATION,
`endif
    output logic [NUM_BANKS-1:0] OE_n,
    output logic [NUM_BANKS-1:0] WE_ODD_n,
    output logic [NUM_BANKS-1:0] WE_EVEN_n,
    output logic                 RAM_ACCESS,
    output logic                 DTACK_n
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DONE} state_t;

    state_t                 state_reg, state_next;
    logic [2:0]             cnt_reg, cnt_next;
    logic [NUM_BANKS-1:0]   bank_reg, bank_next;
    logic                   rw_reg, rw_next;
    logic [NUM_BANKS-1:0]   oe_n_reg, oe_n_next;
    logic [NUM_BANKS-1:0]   we_odd_n_reg, we_odd_n_next;
    logic [NUM_BANKS-1:0]   we_even_n_reg, we_even_n_next;
    logic                   ram_access_reg, ram_access_next;
    logic                   dtack_n_reg, dtack_n_next;

    logic [2:0]             offset;
    logic [NUM_BANKS-1:0]   bank_sel_dec;
    logic                   hit;
    logic [NUM_BANKS-1:0]   sel;
    logic                   rw_sel;
    logic                   wr_blocked;

    // Slot offset wraps modulo 8 so a board based near the top of the Z2 window still decodes.
    assign offset = A - BASE_RAM;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_dec
            localparam logic [3:0] HI = 4'((gi + 1) * SLOTS_PER_BANK);
            localparam logic [3:0] LO = 4'(gi * SLOTS_PER_BANK);
            if (gi == 0) begin : g_first
                assign bank_sel_dec[gi] = ({1'b0, offset} < HI);
            end else begin : g_rest
                assign bank_sel_dec[gi] = ({1'b0, offset} >= LO) && ({1'b0, offset} < HI);
            end
        end
    endgenerate

    assign hit = !AS_n && !RAM_CONFIGURED_n && (|(bank_sel_dec & BANK_EN));

    // In IDLE the strobes follow the live decode; afterwards only the latched cycle attributes count.
    assign sel    = (state_reg == S_IDLE) ? bank_sel_dec : bank_reg;
    assign rw_sel = (state_reg == S_IDLE) ? RW_n : rw_reg;

`ifdef FASTRAM_WP_EN
    logic wp_reg, wp_next;
    logic wp_violation_reg, wp_violation_next;

    assign wr_blocked = (state_reg == S_IDLE) ? (|(bank_sel_dec & WP_MASK)) : wp_reg;
    assign wp_next    = wr_blocked;
    assign wp_violation_next = wp_violation_reg |
        ((state_next == S_ACK) && (state_reg != S_ACK) && !rw_sel && wr_blocked);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wp_reg           <= 1'b0;
            wp_violation_reg <= 1'b0;
        end else begin
            if (state_reg == S_IDLE) wp_reg <= wp_next;
            wp_violation_reg <= wp_violation_next;
        end
    end

    assign WP_VIOLATION = wp_violation_reg;
`else
    assign wr_blocked = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 3'd0;
            bank_reg       <= '0;
            rw_reg         <= 1'b1;
            oe_n_reg       <= '1;
            we_odd_n_reg   <= '1;
            we_even_n_reg  <= '1;
            ram_access_reg <= 1'b0;
            dtack_n_reg    <= 1'b1;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bank_reg       <= bank_next;
            rw_reg         <= rw_next;
            oe_n_reg       <= oe_n_next;
            we_odd_n_reg   <= we_odd_n_next;
            we_even_n_reg  <= we_even_n_next;
            ram_access_reg <= ram_access_next;
            dtack_n_reg    <= dtack_n_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bank_next  = bank_reg;
        rw_next    = rw_reg;
        case (state_reg)
            S_IDLE: begin
                if (hit) begin
                    bank_next  = bank_sel_dec;
                    rw_next    = RW_n;
                    cnt_next   = 3'(WAIT_STATES);
                    state_next = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 3'd1;
                if (AS_n)                state_next = S_DONE;
                else if (cnt_reg == 3'd1) state_next = S_ACK;
            end
            S_ACK: begin
                if (AS_n) state_next = S_DONE;
            end
            default: begin
                cnt_next   = 3'd0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Output registers are loaded from the state being entered, so strobes track sampled DS one edge later.
    always_comb begin
        oe_n_next       = '1;
        we_odd_n_next   = '1;
        we_even_n_next  = '1;
        ram_access_next = 1'b0;
        dtack_n_next    = 1'b1;
        if (state_next == S_WAIT || state_next == S_ACK) begin
            ram_access_next = 1'b1;
            dtack_n_next    = (state_next != S_ACK);
            if (rw_sel) begin
                oe_n_next = ~(sel & {NUM_BANKS{!(UDS_n & LDS_n)}});
            end else if (!wr_blocked) begin
                we_even_n_next = ~(sel & {NUM_BANKS{!UDS_n}});
                we_odd_n_next  = ~(sel & {NUM_BANKS{!LDS_n}});
            end
        end
    end

    assign OE_n       = oe_n_reg;
    assign WE_ODD_n   = we_odd_n_reg;
    assign WE_EVEN_n  = we_even_n_reg;
    assign RAM_ACCESS = ram_access_reg;
    assign DTACK_n    = dtack_n_reg;

endmodule

// File: tb/tb_fastram_ctrl.sv
// Directed bench for fastram_ctrl: one instance with one wait state, one with three, sharing the bus inputs.
module tb_fastram_ctrl;

    logic       CLK;
    logic       RESET_n;
    logic [2:0] A;
    logic       RW_n, UDS_n, LDS_n, AS_n;
    logic [2:0] BASE_RAM;
    logic       RAM_CONFIGURED_n;
    logic [1:0] BANK_EN;
    logic [1:0] oe_n, we_odd_n, we_even_n;
    logic       ram_access, dtack_n;
    logic [1:0] oe_n_3, we_odd_n_3, we_even_n_3;
    logic       ram_access_3, dtack_n_3;
`ifdef FASTRAM_WP_EN
    logic [1:0] WP_MASK;
    logic       wp_violation, wp_violation_3;
`endif

    int checks   = 0;
    int failures = 0;

    fastram_ctrl #(.NUM_BANKS(2), .SLOTS_PER_BANK(2), .WAIT_STATES(1)) u_dut (
        .CLK(CLK), .RESET_n(RESET_n), .A(A), .RW_n(RW_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
        .AS_n(AS_n), .BASE_RAM(BASE_RAM), .RAM_CONFIGURED_n(RAM_CONFIGURED_n), .BANK_EN(BANK_EN),
`ifdef FASTRAM_WP_EN
        .WP_MASK(WP_MASK), .WP_VIOLATION(wp_violation),
`endif
        .OE_n(oe_n), .WE_ODD_n(we_odd_n), .WE_EVEN_n(we_even_n),
        .RAM_ACCESS(ram_access), .DTACK_n(dtack_n)
    );

    fastram_ctrl #(.NUM_BANKS(2), .SLOTS_PER_BANK(2), .WAIT_STATES(3)) u_dut_ws3 (
        .CLK(CLK), .RESET_n(RESET_n), .A(A), .RW_n(RW_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
        .AS_n(AS_n), .BASE_RAM(BASE_RAM), .RAM_CONFIGURED_n(RAM_CONFIGURED_n), .BANK_EN(BANK_EN),
`ifdef FASTRAM_WP_EN
        .WP_MASK(WP_MASK), .WP_VIOLATION(wp_violation_3),
`endif
        .OE_n(oe_n_3), .WE_ODD_n(we_odd_n_3), .WE_EVEN_n(we_even_n_3),
        .RAM_ACCESS(ram_access_3), .DTACK_n(dtack_n_3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        AS_n  = 1'b1;
        UDS_n = 1'b1;
        LDS_n = 1'b1;
        RW_n  = 1'b1;
    endtask

    task automatic start_read();
        RW_n  = 1'b1;
        AS_n  = 1'b0;
        UDS_n = 1'b0;
        LDS_n = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_n          = 1'b0;
        bus_idle();
        A                = 3'b010;
        BASE_RAM         = 3'b001;
        RAM_CONFIGURED_n = 1'b0;
        BANK_EN          = 2'b11;
`ifdef FASTRAM_WP_EN
        WP_MASK          = 2'b00;
`endif
        tick();
        check_eq("rst_oe", 8'(oe_n), 8'h3);
        check_eq("rst_we", 8'({we_even_n, we_odd_n}), 8'hf);
        check_eq("rst_acc", 8'(ram_access), 8'h0);
        check_eq("rst_dtack", 8'(dtack_n), 8'h1);
        tick();
        RESET_n = 1'b1;
        tick();
        $display("txn reset done");

        // Word read: offset 1 -> bank 0
        start_read();
        tick();
        check_eq("rd_oe_e1", 8'(oe_n), 8'h2);
        check_eq("rd_acc_e1", 8'(ram_access), 8'h1);
        check_eq("rd_dtack_e1", 8'(dtack_n), 8'h1);
        tick();
        check_eq("rd_dtack_e2", 8'(dtack_n), 8'h0);
        check_eq("rd_oe_e2", 8'(oe_n), 8'h2);
        bus_idle();
        tick();
        check_eq("rd_oe_rel", 8'(oe_n), 8'h3);
        check_eq("rd_dtack_rel", 8'(dtack_n), 8'h1);
        check_eq("rd_acc_rel", 8'(ram_access), 8'h0);
        tick();
        $display("txn word_read done");

        // Wrap: base 7, A 1 -> offset 2 -> bank 1
        BASE_RAM = 3'b111;
        A        = 3'b001;
        start_read();
        tick();
        check_eq("wrap_oe", 8'(oe_n), 8'h1);
        bus_idle();
        tick();
        tick();
        BANK_EN = 2'b01;
        start_read();
        tick();
        check_eq("wrap_dis_oe", 8'(oe_n), 8'h3);
        check_eq("wrap_dis_acc", 8'(ram_access), 8'h0);
        tick();
        check_eq("wrap_dis_dtack", 8'(dtack_n), 8'h1);
        bus_idle();
        tick();
        BANK_EN = 2'b11;
        $display("txn wrap done");

        // Offset 4 is beyond the 8MB window of two 4MB banks
        BASE_RAM = 3'b001;
        A        = 3'b101;
        start_read();
        tick();
        check_eq("range_acc", 8'(ram_access), 8'h0);
        check_eq("range_oe", 8'(oe_n), 8'h3);
        bus_idle();
        tick();
        A                = 3'b001;
        RAM_CONFIGURED_n = 1'b1;
        start_read();
        tick();
        check_eq("unconf_acc", 8'(ram_access), 8'h0);
        bus_idle();
        RAM_CONFIGURED_n = 1'b0;
        tick();
        $display("txn no_hit done");

        // Late low-byte write to bank 0
        A    = 3'b001;
        RW_n = 1'b0;
        AS_n = 1'b0;
        tick();
        check_eq("bw_acc_e1", 8'(ram_access), 8'h1);
        check_eq("bw_we_e1", 8'({we_even_n, we_odd_n}), 8'hf);
        tick();
        check_eq("bw_dtack_e2", 8'(dtack_n), 8'h0);
        check_eq("bw_we_e2", 8'({we_even_n, we_odd_n}), 8'hf);
        LDS_n = 1'b0;
        tick();
        check_eq("bw_we_odd", 8'(we_odd_n), 8'h2);
        check_eq("bw_we_even", 8'(we_even_n), 8'h3);
        check_eq("bw_oe", 8'(oe_n), 8'h3);
        LDS_n = 1'b1;
        tick();
        check_eq("bw_we_odd_rel", 8'(we_odd_n), 8'h3);
        check_eq("bw_dtack_hold", 8'(dtack_n), 8'h0);
        bus_idle();
        tick();
        check_eq("bw_dtack_rel", 8'(dtack_n), 8'h1);
        check_eq("bw_acc_rel", 8'(ram_access), 8'h0);
        tick();
        $display("txn byte_write done");

        // Abort during wait states on the three-wait instance
        start_read();
        tick();
        check_eq("ab_acc_e1", 8'(ram_access_3), 8'h1);
        check_eq("ab_oe_e1", 8'(oe_n_3), 8'h2);
        tick();
        check_eq("ab_dtack_e2", 8'(dtack_n_3), 8'h1);
        bus_idle();
        tick();
        check_eq("ab_dtack_e3", 8'(dtack_n_3), 8'h1);
        check_eq("ab_acc_e3", 8'(ram_access_3), 8'h0);
        check_eq("ab_oe_e3", 8'(oe_n_3), 8'h3);
        start_read();
        tick();
        check_eq("ab_dead", 8'(ram_access_3), 8'h0);
        tick();
        check_eq("ab_new_acc", 8'(ram_access_3), 8'h1);
        tick();
        tick();
        check_eq("ws3_dtack_e3", 8'(dtack_n_3), 8'h1);
        tick();
        check_eq("ws3_dtack_e4", 8'(dtack_n_3), 8'h0);
        bus_idle();
        tick();
        tick();
        $display("txn abort done");

        // Configuration and address changes mid-cycle are ignored
        start_read();
        tick();
        tick();
        check_eq("mid_dtack", 8'(dtack_n), 8'h0);
        RAM_CONFIGURED_n = 1'b1;
        A                = 3'b110;
        tick();
        check_eq("mid_dtack_hold", 8'(dtack_n), 8'h0);
        check_eq("mid_oe_hold", 8'(oe_n), 8'h2);
        check_eq("mid_acc_hold", 8'(ram_access), 8'h1);
        bus_idle();
        tick();
        check_eq("mid_acc_rel", 8'(ram_access), 8'h0);
        RAM_CONFIGURED_n = 1'b0;
        A                = 3'b001;
        tick();
        $display("txn mid_cycle done");

`ifdef FASTRAM_WP_EN
        WP_MASK = 2'b01;
        RW_n  = 1'b0;
        AS_n  = 1'b0;
        UDS_n = 1'b0;
        LDS_n = 1'b0;
        tick();
        check_eq("wp_we_e1", 8'({we_even_n, we_odd_n}), 8'hf);
        tick();
        check_eq("wp_we_e2", 8'({we_even_n, we_odd_n}), 8'hf);
        check_eq("wp_dtack", 8'(dtack_n), 8'h0);
        check_eq("wp_viol", 8'(wp_violation), 8'h1);
        bus_idle();
        tick();
        tick();
        check_eq("wp_sticky", 8'(wp_violation), 8'h1);
        A     = 3'b011;
        RW_n  = 1'b0;
        AS_n  = 1'b0;
        UDS_n = 1'b0;
        tick();
        check_eq("wp_bank1_we", 8'(we_even_n), 8'h1);
        bus_idle();
        tick();
        tick();
        A = 3'b001;
        $display("txn write_protect done");
`endif

        // Asynchronous reset while in ACK
        start_read();
        tick();
        tick();
        check_eq("ar_dtack_pre", 8'(dtack_n), 8'h0);
        #1;
        RESET_n = 1'b0;
        #1;
        check_eq("ar_dtack", 8'(dtack_n), 8'h1);
        check_eq("ar_oe", 8'(oe_n), 8'h3);
        check_eq("ar_acc", 8'(ram_access), 8'h0);
`ifdef FASTRAM_WP_EN
        check_eq("ar_wp_clr", 8'(wp_violation), 8'h0);
`endif
        bus_idle();
        tick();
        RESET_n = 1'b1;
        tick();
        check_eq("ar_idle_acc", 8'(ram_access), 8'h0);
        start_read();
        tick();
        check_eq("ar_new_acc", 8'(ram_access), 8'h1);
        bus_idle();
        tick();
        tick();
        $display("txn async_reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
